serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per cycle, LSB first,
// and reports the difference, the final borrow and signed overflow with a done pulse.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       bit_res;

  // Full-subtractor cell: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic ai, input logic bi, input logic bri);
    logic d;
    logic bn;
    d  = ai ^ bi ^ bri;
    bn = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bn, d};
  endfunction

  // Signed overflow only possible when operand signs differ and the result sign
  // disagrees with the minuend.
  function automatic logic sub_ovf(input logic am, input logic bm, input logic dm);
    return (am != bm) && (dm != am);
  endfunction

  assign bit_res = sub_bit(a_sh[0], b_sh[0], br);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      work       <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= borrow_in;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SUB;
          end
        end
        SUB: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= bit_res[1];
          work <= {bit_res[0], work[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          // The bit finishing now is the MSB: publish the result directly.
          if (cnt == LAST_BIT) begin
            diff       <= {bit_res[0], work[WIDTH-1:1]};
            borrow_out <= bit_res[1];
            overflow   <= sub_ovf(a_msb, b_msb, bit_res[0]);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and exhaustive check of serial_subtractor (WIDTH=4) against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_d  = 0;
  int exp_bo = 0;
  int exp_ov = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) chk("busy_done_excl", int'(busy & done), 0);
  end

  // Reference: plain unsigned and signed arithmetic on the operand values.
  task automatic model(input int av, input int bv, input int bin,
                       output int d, output int bo, output int ov);
    int full;
    int sa;
    int sb;
    int r;
    full = av - bv - bin;
    d    = full & ((1 << W) - 1);
    bo   = (av < bv + bin) ? 1 : 0;
    sa   = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
    sb   = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
    r    = sa - sb - bin;
    ov   = (r < -(1 << (W - 1)) || r > (1 << (W - 1)) - 1) ? 1 : 0;
  endtask

  task automatic check_result(input string tag, input int av, input int bv, input int bin);
    int d, bo, ov;
    model(av, bv, bin, d, bo, ov);
    chk({tag, "_diff"}, int'(diff), d);
    chk({tag, "_borrow"}, int'(borrow_out), bo);
    chk({tag, "_ovf"}, int'(overflow), ov);
    exp_d  = d;
    exp_bo = bo;
    exp_ov = ov;
  endtask

  // One isolated operation from IDLE; optionally pulses a stray start during SUB.
  task automatic run_op(input string tag, input int av, input int bv, input int bin,
                        input bit interfere);
    @(negedge clk);
    a = W'(av); b = W'(bv); borrow_in = bin[0]; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_done_early"}, int'(done), 0);
      chk({tag, "_hold"}, int'(diff), exp_d);
      chk({tag, "_hold_bo"}, int'(borrow_out), exp_bo);
      start = (interfere && k == 1);
      if (interfere && k == 1) begin
        a = W'(1); b = W'(1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
    check_result(tag, av, bv, bin);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    if (interfere) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk({tag, "_stray_start"}, int'(done | busy), 0);
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int last_cyc;
    rst = 1'b1; start = 1'b1; a = W'(9); b = W'(3); borrow_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bo", int'(borrow_out), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", int'(busy), 0);

    run_op("v9m3", 9, 3, 0, 1'b0);
    run_op("v3m9", 3, 9, 0, 1'b0);
    run_op("v0m0b", 0, 0, 1, 1'b0);
    run_op("v8m1", 8, 1, 0, 1'b0);
    run_op("stray", 9, 3, 0, 1'b1);

    // Abort mid-SUB.
    @(negedge clk);
    a = W'(9); b = W'(3); borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bo", int'(borrow_out), 0);
    chk("abort_ovf", int'(overflow), 0);
    exp_d = 0; exp_bo = 0; exp_ov = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done | busy), 0);
    end
    run_op("after_abort", 5, 2, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op("rand", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
             int'($urandom_range(1, 0)), 1'($urandom));
    end

    // Exhaustive, start held high, back-to-back.
    @(negedge clk);
    a = W'(0); b = W'(0); borrow_in = 1'b0; start = 1'b1;
    last_cyc = 0;
    for (int idx = 0; idx < 512; idx++) begin
      wait_done(ok);
      if (!ok) begin
        chk("exh_done_timeout", 0, 1);
        break;
      end
      check_result("exh", (idx >> 5) & 15, (idx >> 1) & 15, idx & 1);
      if (idx > 0) chk("exh_spacing", cyc - last_cyc, W + 2);
      last_cyc = cyc;
      if (idx < 511) begin
        a = W'(((idx + 1) >> 5) & 15);
        b = W'(((idx + 1) >> 1) & 15);
        borrow_in = 1'((idx + 1) & 1);
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
